// File: rtl/boot_hex_formatter.sv
// Purpose: turns each accepted binary word into one ASCII hex text line (MSB digit first, then CR LF).
// Latency: the first character is valid one cycle after the word is accepted; one character per output transfer.
// Backpressure: out_char holds while out_valid & !out_ready; in_ready is low for the whole line, so no word is dropped.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   in_valid/in_ready     word handshake; in_ready is high only while no line is in progress
//   in_address, in_data   word to format (the address is used only with BOOT_HEX_FORMATTER_ADDRESS_EN)
//   out_valid/out_ready   character handshake towards the sink
//   out_char              ASCII character
//   busy                  high while a line is in progress
//
// Optional feature: define BOOT_HEX_FORMATTER_ADDRESS_EN to prefix every line with
// "<address hex digits>: ". Without it, in_address is ignored.
module boot_hex_formatter #(
    parameter int address_width = 32,
    parameter int data_width    = 32,
    parameter int char_width    = 8,
    parameter bit uppercase     = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [address_width-1:0] in_address,
    input  logic [data_width-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [char_width-1:0]    out_char,
    output logic                     busy
);

    localparam int DATA_DIGITS = data_width / 4;
    localparam int CNT_W       = (DATA_DIGITS > 1) ? $clog2(DATA_DIGITS) : 1;

`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
    localparam int ADDR_DIGITS = address_width / 4;
    localparam int ACNT_W      = (ADDR_DIGITS > 1) ? $clog2(ADDR_DIGITS) : 1;
`endif

    localparam logic [7:0] ALPHA_BASE = uppercase ? 8'h41 : 8'h61;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
        ADDR = 3'd1,
        SEP  = 3'd2,
`endif
        DATA = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [data_width-1:0]  data_sr;
    logic [CNT_W-1:0]       nib_cnt;
    logic [7:0]             char_c;
    logic                   load;
    logic                   advance;

`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
    logic [address_width-1:0] addr_sr;
    logic [ACNT_W-1:0]        addr_cnt;
    // 0 while ':' is presented, 1 while the following space is presented
    logic                     sep_cnt;
`else
    logic unused_address;
    assign unused_address = ^in_address;
`endif

    // Maps one nibble to its ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return ALPHA_BASE + {4'h0, n} - 8'd10;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign load      = in_valid & in_ready;
    assign advance   = out_valid & out_ready;
    assign out_char  = char_width'(char_c);

    // Next-state and character selection; only output transfers move the line forward.
    always_comb begin
        state_next = state;
        char_c     = 8'h00;
        case (state)
            IDLE: begin
                if (load) begin
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
                    state_next = ADDR;
`else
                    state_next = DATA;
`endif
                end
            end
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
            ADDR: begin
                char_c = hex_char(addr_sr[address_width-1 -: 4]);
                if (advance && addr_cnt == ACNT_W'(ADDR_DIGITS - 1)) begin
                    state_next = SEP;
                end
            end
            SEP: begin
                char_c = sep_cnt ? 8'h20 : 8'h3A;
                if (advance && sep_cnt) begin
                    state_next = DATA;
                end
            end
`endif
            DATA: begin
                char_c = hex_char(data_sr[data_width-1 -: 4]);
                if (advance && nib_cnt == CNT_W'(DATA_DIGITS - 1)) begin
                    state_next = CR;
                end
            end
            CR: begin
                char_c = 8'h0D;
                if (advance) begin
                    state_next = LF;
                end
            end
            LF: begin
                char_c = 8'h0A;
                if (advance) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            data_sr <= '0;
            nib_cnt <= '0;
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
            addr_sr  <= '0;
            addr_cnt <= '0;
            sep_cnt  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (load) begin
                data_sr <= in_data;
                nib_cnt <= '0;
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
                addr_sr  <= in_address;
                addr_cnt <= '0;
                sep_cnt  <= 1'b0;
`endif
            end else if (advance) begin
                case (state)
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
                    ADDR: begin
                        addr_sr <= addr_sr << 4;
                        // counter stops at the last digit so it never wraps inside a line
                        if (addr_cnt != ACNT_W'(ADDR_DIGITS - 1)) begin
                            addr_cnt <= addr_cnt + ACNT_W'(1);
                        end
                    end
                    SEP: begin
                        sep_cnt <= 1'b1;
                    end
`endif
                    DATA: begin
                        data_sr <= data_sr << 4;
                        if (nib_cnt != CNT_W'(DATA_DIGITS - 1)) begin
                            nib_cnt <= nib_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_hex_formatter.sv
module tb_boot_hex_formatter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [7:0] u;
        logic [7:0] l;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_address = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b1;

    logic       in_ready_u, out_valid_u, busy_u;
    logic       in_ready_l, out_valid_l, busy_l;
    logic [7:0] out_char_u, out_char_l;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   xfer_count = 0;
    bit   rand_ready = 1'b0;
    bit   stalled = 1'b0;
    logic [7:0] stall_u, stall_l;

    boot_hex_formatter #(
        .address_width(AW), .data_width(DW), .char_width(8), .uppercase(1'b1)
    ) dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_address(in_address), .in_data(in_data), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_char(out_char_u), .busy(busy_u)
    );

    boot_hex_formatter #(
        .address_width(AW), .data_width(DW), .char_width(8), .uppercase(1'b0)
    ) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_address(in_address), .in_data(in_data), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_char(out_char_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    // Reference: the ASCII spelling of one nibble in both letter cases.
    function automatic exp_t digit(input int n);
        exp_t e;
        e.u = (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
        e.l = (n < 10) ? 8'(48 + n) : 8'(97 + n - 10);
        return e;
    endfunction

    function automatic exp_t same(input logic [7:0] c);
        exp_t e;
        e.u = c;
        e.l = c;
        return e;
    endfunction

    // Reference: the full text line for one word, appended to the scoreboard.
    task automatic push_line(input logic [AW-1:0] addr, input logic [DW-1:0] data);
`ifdef BOOT_HEX_FORMATTER_ADDRESS_EN
        for (int i = AW / 4 - 1; i >= 0; i--) exp_q.push_back(digit(int'((addr >> (4 * i)) & 32'hF)));
        exp_q.push_back(same(8'h3A));
        exp_q.push_back(same(8'h20));
`endif
        for (int i = DW / 4 - 1; i >= 0; i--) exp_q.push_back(digit(int'((data >> (4 * i)) & 32'hF)));
        exp_q.push_back(same(8'h0D));
        exp_q.push_back(same(8'h0A));
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit keep_valid);
        bit done = 1'b0;
        in_valid   = 1'b1;
        in_address = addr;
        in_data    = data;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (in_ready_u) begin
                @(posedge clk);
                push_line(addr, data);
                #1;
                if (!keep_valid) in_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // out_ready is changed shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares the DUT against the scoreboard at every falling edge.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            check("in_ready_u", in_ready_u, exp_q.size() == 0);
            check("out_valid_u", out_valid_u, exp_q.size() != 0);
            check("busy_l", busy_l, exp_q.size() != 0);
            check("in_ready_l", in_ready_l, exp_q.size() == 0);
            if (stalled) begin
                check("stall_hold_u", out_char_u, stall_u);
                check("stall_hold_l", out_char_l, stall_l);
            end
            stalled = out_valid_u && !out_ready;
            stall_u = out_char_u;
            stall_l = out_char_l;
            if (out_valid_u && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char", out_char_u, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("char_upper", out_char_u, e.u);
                    check("char_lower", out_char_l, e.l);
                    xfer_count++;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_u, 1'b0);
        check("rst_in_ready", in_ready_u, 1'b1);
        check("rst_out_char", out_char_u, 8'h00);
        check("rst_busy", busy_u, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic line and its lowercase twin.
        send_word(32'h0000_0004, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        send_word(32'h1000_0000, 32'h0000_ABCF, 1'b0);
        wait_idle();

        // Random sink stalls.
        rand_ready = 1'b1;
        send_word(32'h0000_0008, 32'h1234_5678, 1'b0);
        wait_idle();
        rand_ready = 1'b0;

        // Back-to-back words with in_valid held.
        send_word(32'h0000_000C, 32'h0000_0001, 1'b1);
        send_word(32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
        wait_idle();

        // Reset after the third character of a line.
        begin
            int base;
            bit hit = 1'b0;
            base = xfer_count;
            send_word(32'h0000_0014, 32'hCAFE_F00D, 1'b0);
            for (int c = 0; c < 200 && !hit; c++) begin
                @(negedge clk);
                if (xfer_count >= base + 3) hit = 1'b1;
            end
            if (!hit) check("reset_wait_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            check("midrst_out_valid_u", out_valid_u, 1'b0);
            check("midrst_in_ready_u", in_ready_u, 1'b1);
            check("midrst_out_char_u", out_char_u, 8'h00);
            check("midrst_out_valid_l", out_valid_l, 1'b0);
            check("midrst_in_ready_l", in_ready_l, 1'b1);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk);
            #1;
        end
        send_word(32'h0000_0018, 32'h0000_0000, 1'b0);
        wait_idle();

        send_word(32'h0000_0004, 32'h0000_0013, 1'b0);
        wait_idle();

        // Random words, gaps and sink stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_word($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        wait_idle();
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_hex_formatter.md
Name: boot_hex_formatter

Overview:
Converts binary words into ASCII hex text lines for a character sink such as a UART transmitter. Each accepted word becomes data_width/4 hex digits, MSB nibble first, followed by CR LF. This is the output-direction counterpart of the boot hex loader. It is used to dump memory or report loaded words back over the serial link, in the same line format the loader accepts.

Parameters:
address_width, 32, width of in_address
data_width, 32, width of in_data; must be a multiple of 4
char_width, 8, width of out_char
uppercase, 1, 1: digits A-F use 8'h41..8'h46; 0: a-f use 8'h61..8'h66

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  word available
in_ready  output  1  formatter can accept a word
in_address  input  address_width  word address (used only with the optional feature)
in_data  input  data_width  word to format
out_valid  output  1  out_char is valid
out_ready  input  1  sink accepts out_char this cycle
out_char  output  char_width  ASCII character
busy  output  1  line in progress (state != IDLE)

Behaviour:
- Reset: asynchronous and active-high; all state is cleared immediately. Output values under reset: state=IDLE, in_ready=1, out_valid=0, out_char=0, busy=0, counters 0.
- Reset mid-line aborts the line. The partial line is not resumed. The next accepted word starts a fresh line.
- FSM states are IDLE, ADDR (optional), SEP (optional), DATA, CR, LF.
- in_ready = (state==IDLE), derived combinationally from the registered state.
- An input transfer occurs when in_valid & in_ready. On that transfer:
  - in_data is latched into the shift register;
  - in_address is latched if the optional feature is compiled in;
  - nibble counter is cleared;
  - next state is DATA (or ADDR with the feature).
- Latency: out_valid rises on the first clock edge after acceptance.
- out_valid = (state != IDLE).
- out_char is a function of registered state and the shift register only. It holds stable while out_valid & !out_ready.
- An output transfer occurs when out_valid & out_ready. Only output transfers advance digit, counter or state.
- Digit encoding, for top nibble n: n<10 gives 8'h30+n; n>=10 gives base+n-10, where base is 8'h41 (uppercase=1) or 8'h61 (uppercase=0).
- DATA state:
  - each output transfer shifts the register left by 4 and increments the counter;
  - after the transfer of digit data_width/4-1 the next state is CR.
- CR: out_char=8'h0D; transfer moves to LF.
- LF: out_char=8'h0A; transfer moves to IDLE.
- Back-to-back words: in_ready is 1 in the cycle after the LF transfer. Minimum line period is (chars per line + 1) cycles.
- No words are ever dropped; in_valid while busy is simply not accepted.
- Counter width is $clog2(data_width/4) bits, using at least 1 bit. There is no wrap-around inside a line.

Optional Feature:
- Macro: BOOT_HEX_FORMATTER_ADDRESS_EN.
- Defined:
  - each line is prefixed with address_width/4 address hex digits, MSB first, then ':' (8'h3A) and space (8'h20);
  - state order is ADDR, SEP (two characters), DATA, CR, LF;
  - address digits use the same encoding rules as data digits.
- Undefined:
  - ADDR and SEP do not exist and in_address is ignored;
  - lines contain data digits plus CR LF only.

Test Plan:
- Basic word: uppercase=1, in_data=32'hDEADBEEF, out_ready held 1 -> out_char sequence 44 45 41 44 42 45 45 46 0D 0A, one per cycle. First char appears 1 cycle after acceptance; in_ready returns 1 after the LF.
- Lowercase: uppercase=0, in_data=32'h0000ABCF -> 30 30 30 30 61 62 63 66 0D 0A.
- Backpressure: out_ready toggles randomly during 32'h12345678 -> out_char stable while stalled; sequence 31..38 0D 0A exactly once, no duplicates or drops; in_ready stays 0 throughout.
- Back-to-back: in_valid held with 32'h00000001 then 32'hFFFFFFFF -> second word is accepted in the cycle after the first LF transfer. Lines arrive in order and intact.
- Reset mid-line: assert reset after the 3rd character of 32'hCAFEF00D -> out_valid=0 and in_ready=1 immediately. After release, word 32'h00000000 yields eight 30s then 0D 0A.
- Feature on: in_address=32'h00000004, in_data=32'h00000013 -> 30 30 30 30 30 30 30 34 3A 20 30 30 30 30 30 30 31 33 0D 0A.
